// File: rtl/pipe_flush_ctrl.sv
// Pipeline flush / fetch redirect sequencer.
// On a WB exception or ERET commit it pulses flush, latches the redirect
// target, drains inst-SRAM responses belonging to the squashed fetch stream
// and then offers the target PC to pre-IF until it is accepted.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | normal fetch; watching WB for an exception/ERET commit
// DRAIN    | squashed fetches still in flight; every data_ok is dropped
// REDIRECT | redirect_pc offered to pre-IF, waiting for redirect_ack
module pipe_flush_ctrl #(
  parameter logic [31:0] EX_ENTRY = 32'hbfc00380,
  parameter int          OUTST_W  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_ex,
  input  logic        ws_eret,
  input  logic [31:0] cp0_epc,
  input  logic        inst_req_fire,
  input  logic        inst_data_ok,
  output logic        flush,
  output logic        discard_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [OUTST_W-1:0]   outst_cnt, outst_nxt;
  logic [OUTST_W-1:0]   discard_cnt, discard_nxt;
  logic [31:0]          target, target_nxt;
  logic                 flush_evt;

  assign flush_evt = ws_ex | ws_eret;

  // Requests in flight after this cycle; also seeds the drain count so a
  // same-cycle request/response on the commit cycle is accounted for.
  always_comb begin
    outst_nxt = outst_cnt
              + {{(OUTST_W-1){1'b0}}, inst_req_fire}
              - {{(OUTST_W-1){1'b0}}, inst_data_ok};
  end

  // State, counters and target register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      outst_cnt   <= '0;
      discard_cnt <= '0;
      target      <= '0;
    end else begin
      state       <= state_nxt;
      outst_cnt   <= outst_nxt;
      discard_cnt <= discard_nxt;
      target      <= target_nxt;
    end
  end

  // Next-state and output decode; outputs default to inactive.
  always_comb begin
    state_nxt      = state;
    discard_nxt    = discard_cnt;
    target_nxt     = target;
    flush          = 1'b0;
    discard_data   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = 1'b0;
    case (state)
      IDLE: begin
        flush        = flush_evt;
        discard_data = flush_evt & inst_data_ok;
        if (flush_evt) begin
          // Exception wins over a simultaneous ERET.
          target_nxt  = ws_ex ? EX_ENTRY : cp0_epc;
          discard_nxt = outst_nxt;
          state_nxt   = (outst_nxt != '0) ? DRAIN : REDIRECT;
        end
      end
      DRAIN: begin
        busy         = 1'b1;
        discard_data = inst_data_ok;
        if (inst_data_ok) begin
          discard_nxt = discard_cnt - OUTST_W'(1);
          if (discard_cnt == OUTST_W'(1)) state_nxt = REDIRECT;
        end
      end
      REDIRECT: begin
        busy           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        if (redirect_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed bench for pipe_flush_ctrl: a cycle-by-cycle vector table plus a
// hand-written sequence for a stalled redirect with an ignored event.
module tb_pipe_flush_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_ex, ws_eret;
  logic [31:0] cp0_epc;
  logic        inst_req_fire, inst_data_ok;
  logic        flush, discard_data, redirect_valid, busy;
  logic [31:0] redirect_pc;
  logic        redirect_ack;

  localparam logic [31:0] EXV = 32'hbfc00380;
  localparam logic [31:0] EPC = 32'hbfc01234;

  int pass_cnt = 0;
  int total    = 0;
  int model_outst = 0;

  pipe_flush_ctrl dut (
    .clk(clk), .reset(reset), .ws_ex(ws_ex), .ws_eret(ws_eret),
    .cp0_epc(cp0_epc), .inst_req_fire(inst_req_fire),
    .inst_data_ok(inst_data_ok), .flush(flush), .discard_data(discard_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ex, eret, fire, ok, ack;
    logic [31:0] epc;
    logic        e_flush, e_disc, e_rv, e_busy;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, ex, eret, input logic [31:0] epc,
                              input logic fire, ok, ack,
                              input logic e_flush, e_disc, e_rv,
                              input logic [31:0] e_pc, input logic e_busy);
    vec_t v;
    v.rst = rst; v.ex = ex; v.eret = eret; v.epc = epc;
    v.fire = fire; v.ok = ok; v.ack = ack;
    v.e_flush = e_flush; v.e_disc = e_disc; v.e_rv = e_rv;
    v.e_pc = e_pc; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk1(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic check_outs(input int idx, input logic e_flush, e_disc, e_rv,
                            input logic [31:0] e_pc, input logic e_busy);
    chk1("flush", idx, {31'd0, flush}, {31'd0, e_flush});
    chk1("discard_data", idx, {31'd0, discard_data}, {31'd0, e_disc});
    chk1("redirect_valid", idx, {31'd0, redirect_valid}, {31'd0, e_rv});
    chk1("redirect_pc", idx, redirect_pc, e_pc);
    chk1("busy", idx, {31'd0, busy}, {31'd0, e_busy});
  endtask

  task automatic drive(input logic rst, ex, eret, input logic [31:0] epc,
                       input logic fire, ok, ack);
    reset = rst; ws_ex = ex; ws_eret = eret; cp0_epc = epc;
    inst_req_fire = fire; inst_data_ok = ok; redirect_ack = ack;
  endtask

  // Outstanding-request model of the bench's own stimulus; over/underflow
  // would mean the stimulus itself is illegal.
  always @(posedge clk) begin
    if (reset === 1'b1) model_outst = 0;
    else begin
      model_outst = model_outst + int'(inst_req_fire) - int'(inst_data_ok);
      if (model_outst < 0 || model_outst > 3) begin
        total++;
        $display("FAIL outst_range: got %0d expected 0..3", model_outst);
      end
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // Scenario 1: ws_ex with nothing in flight.
    vecs.push_back(mk(1,0,0,0,     0,0,0, 0,0,0,0,   0));
    vecs.push_back(mk(0,0,0,0,     0,0,0, 0,0,0,0,   0));
    vecs.push_back(mk(0,1,0,0,     0,0,0, 1,0,0,0,   0));
    vecs.push_back(mk(0,0,0,0,     0,0,0, 0,0,1,EXV, 1));
    vecs.push_back(mk(0,0,0,0,     0,0,0, 0,0,1,EXV, 1));
    vecs.push_back(mk(0,0,0,0,     1,0,1, 0,0,1,EXV, 1));
    vecs.push_back(mk(0,0,0,0,     0,1,0, 0,0,0,0,   0));
    // Scenario 2: ERET with two requests in flight.
    vecs.push_back(mk(0,0,0,EPC,   1,0,0, 0,0,0,0,   0));
    vecs.push_back(mk(0,0,0,EPC,   1,0,0, 0,0,0,0,   0));
    vecs.push_back(mk(0,0,1,EPC,   0,0,0, 1,0,0,0,   0));
    vecs.push_back(mk(0,0,0,EPC,   0,0,0, 0,0,0,0,   1));
    vecs.push_back(mk(0,0,0,EPC,   0,1,0, 0,1,0,0,   1));
    vecs.push_back(mk(0,0,0,EPC,   0,1,0, 0,1,0,0,   1));
    vecs.push_back(mk(0,0,0,0,     0,0,0, 0,0,1,EPC, 1));
    vecs.push_back(mk(0,0,0,0,     1,0,1, 0,0,1,EPC, 1));
    // Scenario 3: event, fire and data_ok together with one in flight.
    vecs.push_back(mk(0,1,0,0,     1,1,0, 1,1,0,0,   0));
    vecs.push_back(mk(0,0,0,0,     0,0,0, 0,0,0,0,   1));
    vecs.push_back(mk(0,0,0,0,     0,1,0, 0,1,0,0,   1));
    vecs.push_back(mk(0,0,0,0,     0,0,0, 0,0,1,EXV, 1));
    vecs.push_back(mk(0,0,0,0,     1,0,1, 0,0,1,EXV, 1));
    vecs.push_back(mk(0,0,0,0,     0,1,0, 0,0,0,0,   0));
    // Scenario 4: ws_ex and ws_eret together; exception vector wins.
    vecs.push_back(mk(0,1,1,32'h80000000, 0,0,0, 1,0,0,0,   0));
    vecs.push_back(mk(0,0,0,32'h80000000, 0,0,0, 0,0,1,EXV, 1));
    vecs.push_back(mk(0,0,0,0,     1,0,1, 0,0,1,EXV, 1));
    vecs.push_back(mk(0,0,0,0,     0,1,0, 0,0,0,0,   0));
    // Scenario 5: reset while draining two, then a clean ws_ex.
    vecs.push_back(mk(0,0,0,0,     1,0,0, 0,0,0,0,   0));
    vecs.push_back(mk(0,0,0,0,     1,0,0, 0,0,0,0,   0));
    vecs.push_back(mk(0,1,0,0,     0,0,0, 1,0,0,0,   0));
    vecs.push_back(mk(0,0,0,0,     0,0,0, 0,0,0,0,   1));
    vecs.push_back(mk(1,0,0,0,     0,0,0, 0,0,0,0,   1));
    vecs.push_back(mk(0,0,0,0,     0,0,0, 0,0,0,0,   0));
    vecs.push_back(mk(0,1,0,0,     0,0,0, 1,0,0,0,   0));
    vecs.push_back(mk(0,0,0,0,     0,0,0, 0,0,1,EXV, 1));

    foreach (vecs[i]) begin
      #1;
      drive(vecs[i].rst, vecs[i].ex, vecs[i].eret, vecs[i].epc,
            vecs[i].fire, vecs[i].ok, vecs[i].ack);
      @(negedge clk);
      check_outs(i, vecs[i].e_flush, vecs[i].e_disc, vecs[i].e_rv,
                 vecs[i].e_pc, vecs[i].e_busy);
      @(posedge clk);
    end

    // Scenario 6: ack withheld for 5 cycles, ws_ex during REDIRECT ignored.
    for (int c = 0; c < 5; c++) begin
      #1;
      drive(0, (c == 2), 0, EPC, 0, 0, 0);
      if (c == 2) $display("note: ws_ex while busy (expected to be ignored)");
      @(negedge clk);
      check_outs(100 + c, 0, 0, 1, EXV, 1);
      @(posedge clk);
    end
    #1; drive(0, 0, 0, EPC, 1, 0, 1);
    @(negedge clk); check_outs(105, 0, 0, 1, EXV, 1);
    @(posedge clk);
    #1; drive(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); check_outs(106, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1; drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
